// File: rtl/wakeup_broadcaster.sv
// Wakeup broadcaster: buffers FU completions per source and broadcasts up to WB_WIDTH tags per cycle, round-robin.
// Latency: a completion accepted at an edge is broadcast at the earliest in the next cycle. Busy table updates at the edge.
// Backpressure: fu_ready_o is low when a source FIFO is full (registered count, no same-cycle pop credit) or during flush.
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif

module wakeup_broadcaster #(
  parameter int NUM_SRC     = 4,
  parameter int WB_WIDTH    = `WB_WIDTH,
  parameter int PHY_REG_NUM = `PHY_REG_NUM,
  parameter int FIFO_DEPTH  = 2,
  parameter int NUM_ALLOC   = 2,
  parameter int NUM_LOOKUP  = 4,
  localparam int PW         = $clog2(PHY_REG_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush_i,
  input  logic [NUM_SRC-1:0]                   fu_valid_i,
  input  logic [NUM_SRC-1:0][PW-1:0]           fu_pdest_i,
  output logic [NUM_SRC-1:0]                   fu_ready_o,
  input  logic [NUM_ALLOC-1:0]                 alloc_valid_i,
  input  logic [NUM_ALLOC-1:0][PW-1:0]         alloc_pdest_i,
  input  logic [NUM_LOOKUP-1:0][PW-1:0]        lookup_preg_i,
  output logic [NUM_LOOKUP-1:0]                lookup_ready_o,
  output logic [WB_WIDTH-1:0]                  wb_o,
  output logic [WB_WIDTH-1:0][PW-1:0]          wb_pdest_o
);

  localparam int SW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MEMD = 1 << PTRW;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int KW   = $clog2(WB_WIDTH + 1);

  typedef logic [PW-1:0] preg_t;

  preg_t            mem_q    [NUM_SRC][MEMD];
  preg_t            mem_d    [NUM_SRC][MEMD];
  logic [PTRW-1:0]  rd_ptr_q [NUM_SRC];
  logic [PTRW-1:0]  rd_ptr_d [NUM_SRC];
  logic [PTRW-1:0]  wr_ptr_q [NUM_SRC];
  logic [PTRW-1:0]  wr_ptr_d [NUM_SRC];
  logic [CW-1:0]    cnt_q    [NUM_SRC];
  logic [CW-1:0]    cnt_d    [NUM_SRC];
  logic [SW-1:0]    rr_q, rr_d;
  logic [PHY_REG_NUM-1:0] busy_q, busy_d;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [SW:0]        scan;
  logic [SW-1:0]      src;
  logic [KW-1:0]      k;

  // A source accepts while its registered count is below depth; flush blocks all pushes.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      fu_ready_o[s] = (cnt_q[s] != CW'(FIFO_DEPTH)) & ~flush_i;
    end
    push = fu_valid_i & fu_ready_o;
  end

  // Round-robin scan from rr_q; the k-th non-empty head fills slot k, slots packed from 0.
  always_comb begin
    pop        = '0;
    wb_o       = '0;
    wb_pdest_o = '0;
    rr_d       = rr_q;
    k          = '0;
    scan       = '0;
    src        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan = {1'b0, rr_q} + (SW+1)'(i);
      if (scan >= (SW+1)'(NUM_SRC)) scan = scan - (SW+1)'(NUM_SRC);
      src = scan[SW-1:0];
      if (!flush_i && (cnt_q[src] != '0) && (k < KW'(WB_WIDTH))) begin
        pop[src] = 1'b1;
        for (int j = 0; j < WB_WIDTH; j++) begin
          if (k == KW'(j)) begin
            wb_o[j]       = 1'b1;
            wb_pdest_o[j] = mem_q[src][rd_ptr_q[src]];
          end
        end
        rr_d = (src == SW'(NUM_SRC - 1)) ? '0 : src + 1'b1;
        k    = k + 1'b1;
      end
    end
  end

  // Per-source FIFO pointer/count update; pointers wrap explicitly at FIFO_DEPTH.
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      rd_ptr_d[s] = rd_ptr_q[s];
      wr_ptr_d[s] = wr_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      if (push[s]) begin
        mem_d[s][wr_ptr_q[s]] = fu_pdest_i[s];
        wr_ptr_d[s] = (wr_ptr_q[s] == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q[s] + 1'b1;
      end
      if (pop[s]) begin
        rd_ptr_d[s] = (rd_ptr_q[s] == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q[s] + 1'b1;
      end
      if (push[s] && !pop[s])      cnt_d[s] = cnt_q[s] + 1'b1;
      else if (!push[s] && pop[s]) cnt_d[s] = cnt_q[s] - 1'b1;
      if (flush_i) begin
        rd_ptr_d[s] = '0;
        wr_ptr_d[s] = '0;
        cnt_d[s]    = '0;
      end
    end
  end

  // Busy table: broadcasts clear, allocations set afterwards so a new mapping wins; preg 0 stays ready.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (wb_o[j]) busy_d[wb_pdest_o[j]] = 1'b0;
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_valid_i[a] && (alloc_pdest_i[a] != '0)) busy_d[alloc_pdest_i[a]] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  // Dispatch lookup sees the registered table plus this cycle's broadcasts, so no wakeup is missed.
  always_comb begin
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      lookup_ready_o[i] = ~busy_q[lookup_preg_i[i]];
      for (int j = 0; j < WB_WIDTH; j++) begin
        if (wb_o[j] && (wb_pdest_o[j] == lookup_preg_i[i])) lookup_ready_o[i] = 1'b1;
      end
    end
  end

  // State registers; asynchronous reset drops all buffered completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int e = 0; e < MEMD; e++) mem_q[s][e] <= '0;
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_q   <= '0;
      busy_q <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_wakeup_broadcaster.sv
// Directed bench for wakeup_broadcaster (NUM_SRC=4, WB_WIDTH=2, 64 pregs, FIFO_DEPTH=2).
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_wakeup_broadcaster;
  localparam int NS = 4;
  localparam int WW = 2;
  localparam int PW = 6;
  localparam int NA = 2;
  localparam int NL = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  flush_i;
  logic [NS-1:0]         fu_valid_i;
  logic [NS-1:0][PW-1:0] fu_pdest_i;
  logic [NS-1:0]         fu_ready_o;
  logic [NA-1:0]         alloc_valid_i;
  logic [NA-1:0][PW-1:0] alloc_pdest_i;
  logic [NL-1:0][PW-1:0] lookup_preg_i;
  logic [NL-1:0]         lookup_ready_o;
  logic [WW-1:0]         wb_o;
  logic [WW-1:0][PW-1:0] wb_pdest_o;

  int total;
  int passed;

  wakeup_broadcaster #(
    .NUM_SRC(NS), .WB_WIDTH(WW), .PHY_REG_NUM(64),
    .FIFO_DEPTH(2), .NUM_ALLOC(NA), .NUM_LOOKUP(NL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .fu_valid_i(fu_valid_i), .fu_pdest_i(fu_pdest_i), .fu_ready_o(fu_ready_o),
    .alloc_valid_i(alloc_valid_i), .alloc_pdest_i(alloc_pdest_i),
    .lookup_preg_i(lookup_preg_i), .lookup_ready_o(lookup_ready_o),
    .wb_o(wb_o), .wb_pdest_o(wb_pdest_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush_i       = 1'b0;
    fu_valid_i    = '0;
    fu_pdest_i    = '0;
    alloc_valid_i = '0;
    alloc_pdest_i = '0;
    lookup_preg_i = '0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clr();
    // 1: reset state
    rst_n = 1'b0;
    lookup_preg_i[0] = 6'd5;
    #3;
    chk("rst_lookup5", 32'(lookup_ready_o[0]), 32'd1);
    chk("rst_wb", 32'(wb_o), 32'd0);
    chk("rst_wb_pdest", 32'(wb_pdest_o), 32'd0);
    chk("rst_fu_ready", 32'(fu_ready_o), 32'hF);
    #9 rst_n = 1'b1;

    // 2: alloc 9, FU1 completes 9 two cycles later
    tick(); clr();
    alloc_valid_i = 2'b01; alloc_pdest_i[0] = 6'd9; lookup_preg_i[0] = 6'd9;
    #2 chk("t2_c0_lookup", 32'(lookup_ready_o[0]), 32'd1);
    tick(); clr(); lookup_preg_i[0] = 6'd9;
    #2 chk("t2_c1_lookup", 32'(lookup_ready_o[0]), 32'd0);
    tick(); clr(); lookup_preg_i[0] = 6'd9;
    fu_valid_i = 4'b0010; fu_pdest_i[1] = 6'd9;
    #2 chk("t2_c2_lookup", 32'(lookup_ready_o[0]), 32'd0);
    chk("t2_c2_wb", 32'(wb_o), 32'd0);
    tick(); clr(); lookup_preg_i[0] = 6'd9;
    #2 chk("t2_c3_wb", 32'(wb_o), 32'd1);
    chk("t2_c3_pdest", 32'(wb_pdest_o[0]), 32'd9);
    chk("t2_c3_bypass", 32'(lookup_ready_o[0]), 32'd1);
    tick(); clr(); lookup_preg_i[0] = 6'd9;
    #2 chk("t2_c4_table", 32'(lookup_ready_o[0]), 32'd1);
    chk("t2_c4_wb", 32'(wb_o), 32'd0);

    // reset pulse so round-robin starts at 0
    rst_n = 1'b0; #2 rst_n = 1'b1;

    // 3: all four FUs push 10..13
    tick(); clr();
    fu_valid_i = 4'b1111;
    fu_pdest_i[0] = 6'd10; fu_pdest_i[1] = 6'd11; fu_pdest_i[2] = 6'd12; fu_pdest_i[3] = 6'd13;
    #2 chk("t3_c0_ready", 32'(fu_ready_o), 32'hF);
    chk("t3_c0_wb", 32'(wb_o), 32'd0);
    tick(); clr();
    #2 chk("t3_c1_wb", 32'(wb_o), 32'd3);
    chk("t3_c1_s0", 32'(wb_pdest_o[0]), 32'd10);
    chk("t3_c1_s1", 32'(wb_pdest_o[1]), 32'd11);
    tick(); clr();
    #2 chk("t3_c2_wb", 32'(wb_o), 32'd3);
    chk("t3_c2_s0", 32'(wb_pdest_o[0]), 32'd12);
    chk("t3_c2_s1", 32'(wb_pdest_o[1]), 32'd13);
    tick(); clr();
    fu_valid_i = 4'b1001; fu_pdest_i[0] = 6'd15; fu_pdest_i[3] = 6'd14;
    #2 chk("t3_c3_wb", 32'(wb_o), 32'd0);
    tick(); clr();
    #2 chk("t3_rr0_wb", 32'(wb_o), 32'd3);
    chk("t3_rr0_s0", 32'(wb_pdest_o[0]), 32'd15);
    chk("t3_rr0_s1", 32'(wb_pdest_o[1]), 32'd14);

    // 4: FU0/FU1 stream, FU2 pushes once
    tick(); clr();
    fu_valid_i = 4'b0111;
    fu_pdest_i[0] = 6'd30; fu_pdest_i[1] = 6'd31; fu_pdest_i[2] = 6'd32;
    #2 chk("t4_d0_wb", 32'(wb_o), 32'd0);
    chk("t4_d0_rdy0", 32'(fu_ready_o[0]), 32'd1);
    tick(); clr();
    fu_valid_i = 4'b0011; fu_pdest_i[0] = 6'd30; fu_pdest_i[1] = 6'd31;
    #2 chk("t4_d1_s0", 32'(wb_pdest_o[0]), 32'd30);
    chk("t4_d1_s1", 32'(wb_pdest_o[1]), 32'd31);
    chk("t4_d1_rdy0", 32'(fu_ready_o[0]), 32'd1);
    tick(); clr();
    fu_valid_i = 4'b0011; fu_pdest_i[0] = 6'd30; fu_pdest_i[1] = 6'd31;
    #2 chk("t4_d2_wb", 32'(wb_o), 32'd3);
    chk("t4_d2_s0_fu2", 32'(wb_pdest_o[0]), 32'd32);
    chk("t4_d2_s1", 32'(wb_pdest_o[1]), 32'd30);
    chk("t4_d2_rdy0", 32'(fu_ready_o[0]), 32'd1);
    tick(); clr();
    #2 chk("t4_d3_ready_full1", 32'(fu_ready_o), 32'hD);
    chk("t4_d3_s0", 32'(wb_pdest_o[0]), 32'd31);
    chk("t4_d3_s1", 32'(wb_pdest_o[1]), 32'd30);
    tick(); clr();
    #2 chk("t4_d4_wb", 32'(wb_o), 32'd1);
    chk("t4_d4_s0", 32'(wb_pdest_o[0]), 32'd31);
    chk("t4_d4_s1_zero", 32'(wb_pdest_o[1]), 32'd0);

    // 5: alloc and broadcast of preg 20 in one cycle; alloc of preg 0 ignored
    tick(); clr();
    fu_valid_i = 4'b0001; fu_pdest_i[0] = 6'd20;
    #2 chk("t5_e0_wb", 32'(wb_o), 32'd0);
    tick(); clr();
    alloc_valid_i = 2'b11; alloc_pdest_i[0] = 6'd20; alloc_pdest_i[1] = 6'd0;
    lookup_preg_i[1] = 6'd20; lookup_preg_i[2] = 6'd0;
    #2 chk("t5_e1_wb", 32'(wb_o), 32'd1);
    chk("t5_e1_s0", 32'(wb_pdest_o[0]), 32'd20);
    chk("t5_e1_lookup20", 32'(lookup_ready_o[1]), 32'd1);
    tick(); clr();
    lookup_preg_i[1] = 6'd20; lookup_preg_i[2] = 6'd0;
    #2 chk("t5_e2_set_wins", 32'(lookup_ready_o[1]), 32'd0);
    chk("t5_e2_preg0", 32'(lookup_ready_o[2]), 32'd1);
    chk("t5_e2_wb", 32'(wb_o), 32'd0);

    // 6: flush with three buffered entries
    tick(); clr();
    fu_valid_i = 4'b0111;
    fu_pdest_i[0] = 6'd40; fu_pdest_i[1] = 6'd41; fu_pdest_i[2] = 6'd42;
    #2 chk("t6_f0_wb", 32'(wb_o), 32'd0);
    tick(); clr();
    flush_i = 1'b1; fu_valid_i = 4'b1000; fu_pdest_i[3] = 6'd43;
    alloc_valid_i = 2'b01; alloc_pdest_i[0] = 6'd22; lookup_preg_i[1] = 6'd20;
    #2 chk("t6_f1_wb", 32'(wb_o), 32'd0);
    chk("t6_f1_ready", 32'(fu_ready_o), 32'd0);
    chk("t6_f1_lookup20", 32'(lookup_ready_o[1]), 32'd0);
    tick(); clr();
    lookup_preg_i[1] = 6'd20; lookup_preg_i[2] = 6'd22;
    #2 chk("t6_f2_ready", 32'(fu_ready_o), 32'hF);
    chk("t6_f2_wb", 32'(wb_o), 32'd0);
    chk("t6_f2_lookup20", 32'(lookup_ready_o[1]), 32'd1);
    chk("t6_f2_lookup22", 32'(lookup_ready_o[2]), 32'd1);
    tick(); clr();
    #2 chk("t6_f3_wb", 32'(wb_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
